// File: rtl/sat_sub_pipe.sv
// Two-stage pipelined saturating subtractor (in1 - in2) with valid/ready flow control
// and a saturating count of clamped results handed downstream.
module sat_sub_pipe #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in1,
    input  logic [N-1:0]  in2,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sat_pos,
    output logic          sat_neg,
    input  logic          clr,
    output logic [CW-1:0] sat_cnt
);

    localparam logic [N-1:0]  MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [N:0]    diff_q, diff_d;
    logic          s1_valid_q, s1_valid_d;
    logic [N-1:0]  res_q, res_d;
    logic          sat_pos_q, sat_pos_d;
    logic          sat_neg_q, sat_neg_d;
    logic          s2_valid_q, s2_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic en;
    logic pos_ovf;
    logic neg_ovf;
    logic out_xfer;

    // The top two bits of the exact difference disagree exactly when it does not fit in N bits.
    always_comb begin
        en       = !s2_valid_q || out_ready;
        pos_ovf  = s1_valid_q && (diff_q[N:N-1] == 2'b01);
        neg_ovf  = s1_valid_q && (diff_q[N:N-1] == 2'b10);
        out_xfer = s2_valid_q && out_ready;

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        diff_d     = diff_q;
        s1_valid_d = s1_valid_q;
        res_d      = res_q;
        sat_pos_d  = sat_pos_q;
        sat_neg_d  = sat_neg_q;
        s2_valid_d = s2_valid_q;
        cnt_d      = cnt_q;

        if (en) begin
            diff_d     = {in1[N-1], in1} - {in2[N-1], in2};
            s1_valid_d = in_valid;
            sat_pos_d  = pos_ovf;
            sat_neg_d  = neg_ovf;
            s2_valid_d = s1_valid_q;
            if (pos_ovf) begin
                res_d = MAX_POS;
            end else if (neg_ovf) begin
                res_d = MIN_NEG;
            end else begin
                res_d = diff_q[N-1:0];
            end
        end

        if (clr) begin
            cnt_d = '0;
        end else if (out_xfer && (sat_pos_q || sat_neg_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: reset is synchronous and evaluated first, so it outranks clr, en and any transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_q     <= '0;
            s1_valid_q <= 1'b0;
            res_q      <= '0;
            sat_pos_q  <= 1'b0;
            sat_neg_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            diff_q     <= diff_d;
            s1_valid_q <= s1_valid_d;
            res_q      <= res_d;
            sat_pos_q  <= sat_pos_d;
            sat_neg_q  <= sat_neg_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = en;
    assign out       = res_q;
    assign out_valid = s2_valid_q;
    assign sat_pos   = sat_pos_q;
    assign sat_neg   = sat_neg_q;
    assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_sat_sub_pipe.sv
// Directed and scoreboard-checked stimulus for sat_sub_pipe (N=8, CW=2).
module tb_sat_sub_pipe;

    localparam int N  = 8;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  in1;
    logic [N-1:0]  in2;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  out;
    logic          out_valid;
    logic          out_ready;
    logic          sat_pos;
    logic          sat_neg;
    logic          clr;
    logic [CW-1:0] sat_cnt;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [9:0] exp_e;
    int         model_cnt;

    sat_sub_pipe #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in2       (in2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_pos   (sat_pos),
        .sat_neg   (sat_neg),
        .clr       (clr),
        .sat_cnt   (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in1      = a;
        in2      = b;
    endtask

    task automatic check_out(input string tag, input logic [7:0] o, input logic p, input logic n);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_out"}, out, o);
        check({tag, "_flags"}, {sat_pos, sat_neg}, {p, n});
    endtask

    // Reference: {sat_pos, sat_neg, out} of clamp(a - b) for signed 8-bit operands.
    function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        if (d > 127) return {2'b10, 8'h7F};
        if (d < -128) return {2'b01, 8'h80};
        return {2'b00, 8'(d)};
    endfunction

    // Scoreboard bookkeeping for the cycle whose inputs have just been driven.
    task automatic track;
        #1;
        if (in_valid && in_ready) exp_q.push_back(ref_sub(in1, in2));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("rnd_spurious_out", out_valid, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("rnd_out", out, exp_e[7:0]);
                check("rnd_flags", {sat_pos, sat_neg}, exp_e[9:8]);
                if (!clr && (exp_e[9] || exp_e[8]) && model_cnt < 3) model_cnt++;
            end
        end
        if (clr) model_cnt = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        set_in(1'b1, 8'd7, 8'd2);

        // Reset with a pair presented: it must be discarded.
        repeat (2) cyc;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_flags", {sat_pos, sat_neg}, 0);
        check("rst_cnt", sat_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        set_in(1'b0, 8'd0, 8'd0);
        repeat (2) cyc;
        check("rst_discard", out_valid, 0);

        // Basic vectors, back to back.
        set_in(1'b1, 8'd5, 8'd3);
        cyc;
        check("lat_first_edge", out_valid, 0);
        set_in(1'b1, 8'h80, 8'h80);
        cyc;
        check_out("v_5m3", 8'h02, 0, 0);
        set_in(1'b1, 8'd100, 8'h9C);
        cyc;
        check_out("v_m128mm128", 8'h00, 0, 0);
        set_in(1'b1, 8'h9C, 8'd100);
        cyc;
        check_out("v_pos_sat", 8'h7F, 1, 0);
        check("cnt_before", sat_cnt, 0);
        set_in(1'b0, 8'd0, 8'd0);
        cyc;
        check_out("v_neg_sat", 8'h80, 0, 1);
        check("cnt_one", sat_cnt, 1);
        cyc;
        check("v_drained", out_valid, 0);
        check("cnt_two", sat_cnt, 2);

        // Stall: out_ready low for three cycles once the first result appears.
        set_in(1'b1, 8'd10, 8'd1);
        cyc;
        set_in(1'b1, 8'd20, 8'd5);
        cyc;
        check_out("stall_first", 8'h09, 0, 0);
        out_ready = 1'b0;
        set_in(1'b1, 8'hCE, 8'h1B);
        #1;
        check("stall_in_ready", in_ready, 0);
        repeat (3) begin
            cyc;
            check_out("stall_hold", 8'h09, 0, 0);
            check("stall_in_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", in_ready, 1);
        cyc;
        check_out("stall_p1", 8'h0F, 0, 0);
        set_in(1'b1, 8'hFF, 8'h01);
        cyc;
        check_out("stall_p2", 8'hB3, 0, 0);
        set_in(1'b0, 8'd0, 8'd0);
        cyc;
        check_out("stall_p3", 8'hFE, 0, 0);
        cyc;
        check("stall_no_dup", out_valid, 0);
        check("stall_cnt", sat_cnt, 2);

        // Counter saturation at 3 and clr beating a simultaneous increment.
        clr = 1'b1;
        cyc;
        check("clr_cnt", sat_cnt, 0);
        clr = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            if (j >= 1) check("cnt_seq", sat_cnt, (j == 8) ? 0 : (j < 3) ? 0 : (j - 2 > 3) ? 3 : j - 2);
            if (j >= 2 && j <= 7) check_out("cnt_data", ((j - 2) % 2 == 0) ? 8'h7F : 8'h80,
                                            (j - 2) % 2 == 0, (j - 2) % 2 == 1);
            if (j % 2 == 0) set_in(j < 6, 8'd100, 8'h9C);
            else            set_in(j < 6, 8'h9C, 8'd100);
            clr = (j == 7);
            if (j < 8) cyc;
        end
        clr = 1'b0;
        check("clr_no_data_effect", out_valid, 0);

        // Reset with both stages holding valid data.
        set_in(1'b1, 8'd100, 8'h9C);
        cyc;
        set_in(1'b1, 8'h9C, 8'd100);
        cyc;
        set_in(1'b1, 8'd1, 8'd1);
        cyc;
        check("mid_cnt", sat_cnt, 1);
        check_out("mid_s2", 8'h80, 0, 1);
        rst_n = 1'b0;
        set_in(1'b1, 8'd3, 8'd1);
        cyc;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_flags", {sat_pos, sat_neg}, 0);
        check("mid_rst_cnt", sat_cnt, 0);
        check("mid_rst_ready", in_ready, 1);
        rst_n = 1'b1;
        set_in(1'b0, 8'd0, 8'd0);
        repeat (3) begin
            cyc;
            check("mid_no_stale", out_valid, 0);
        end

        // Random traffic against the clamp reference model.
        model_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            check("rnd_cnt", sat_cnt, model_cnt);
            check("rnd_flags_excl", sat_pos & sat_neg, 0);
            set_in($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 31) == 0);
            track;
            cyc;
        end
        set_in(1'b0, 8'd0, 8'd0);
        out_ready = 1'b1;
        clr       = 1'b0;
        repeat (4) begin
            track;
            cyc;
        end
        check("rnd_drain", exp_q.size(), 0);
        check("rnd_cnt_final", sat_cnt, model_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
